// File: rtl/gray_conv_pkg.sv
// Shared definitions for the Gray/binary conversion arbiter.
//   MODE_B2G / MODE_G2B : per-request conversion direction
//   state_e             : arbiter FSM states
//   rr_pick()           : round-robin search returning {found, idx}
package gray_conv_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Fixed search width. Callers zero-extend their request vector, so this
  // supports up to RR_MAX requesters.
  localparam int unsigned RR_MAX   = 32;
  localparam int unsigned RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_result_t;

  // First set bit of valid, searching ptr, ptr+1, ... with wrap-around.
  // Bits at and above the caller's requester count are zero, so wrapping
  // modulo RR_MAX visits the real requesters in the same order as wrapping
  // modulo R would.
  function automatic rr_result_t rr_pick(input logic [RR_MAX-1:0]   valid,
                                         input logic [RR_IDX_W-1:0] ptr);
    rr_result_t          res;
    logic [RR_IDX_W-1:0] idx;
    res = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = ptr + RR_IDX_W'(k);
      if (!res.found && valid[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gray_bin_conv.sv
// Combinational N-bit binary<->Gray converter.
//   in_i   : word to convert
//   mode_i : MODE_B2G (binary->Gray) or MODE_G2B (Gray->binary)
//   out_o  : converted word
module gray_bin_conv
  import gray_conv_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] in_i,
  input  logic         mode_i,
  output logic [N-1:0] out_o
);

  always_comb begin
    out_o = '0;
    if (mode_i == MODE_B2G) begin
      out_o = in_i ^ (in_i >> 1);
    end else begin
      // Prefix-XOR from the MSB: bit i is the parity of in_i[N-1:i].
      for (int i = 0; i < N; i++) begin
        out_o[i] = ^(in_i >> i);
      end
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one Gray/binary converter between R requesters.
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/ready : per-requester handshake; req_ready is one-hot in IDLE
//   req_data        : requester r's word at [r*N +: N]
//   req_mode        : per-requester conversion direction
//   out_valid/ready : result handshake
//   out_data/out_id : registered result and winning requester index
//   busy            : high while a transaction is in CONV or OUT
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned R = 4,
  localparam int unsigned IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_data,
  input  logic [R-1:0]   req_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic [IDW-1:0] out_id,
  output logic           busy
);

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [N-1:0]     cap_data_q;
  logic             cap_mode_q;
  logic [IDW-1:0]   cap_id_q;
  logic             out_valid_q;
  logic [N-1:0]     out_data_q;
  logic [IDW-1:0]   out_id_q;

  logic [N-1:0]     data_arr [R];
  logic [RR_MAX-1:0] valid_ext;
  rr_result_t       pick;
  logic [IDW-1:0]   grant_idx;
  logic [N-1:0]     conv_out;

  for (genvar r = 0; r < R; r++) begin : g_unpack
    assign data_arr[r] = req_data[r*N +: N];
  end

  always_comb begin
    valid_ext          = '0;
    valid_ext[R-1:0]   = req_valid;
    pick               = rr_pick(valid_ext, RR_IDX_W'(ptr_q));
    grant_idx          = IDW'(pick.idx);
    req_ready          = '0;
    if (state_q == IDLE && pick.found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  gray_bin_conv #(
    .N (N)
  ) u_conv (
    .in_i   (cap_data_q),
    .mode_i (cap_mode_q),
    .out_o  (conv_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cap_data_q  <= '0;
      cap_mode_q  <= 1'b0;
      cap_id_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A found grant always has its req_ready bit set, so this is the accept.
          if (pick.found) begin
            cap_data_q <= data_arr[grant_idx];
            cap_mode_q <= req_mode[grant_idx];
            cap_id_q   <= grant_idx;
            ptr_q      <= (grant_idx == IDW'(R-1)) ? '0 : grant_idx + IDW'(1);
            state_q    <= CONV;
          end
        end
        CONV: begin
          out_data_q  <= conv_out;
          out_id_q    <= cap_id_q;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed-vector bench for gray_conv_arbiter (N=4, R=4) with a scoreboard
// queue filled by the stimulus and drained by an independent output monitor.
module tb_gray_conv_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_data;
  logic [3:0]  req_mode;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_id;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] data;
    logic [1:0] id;
  } exp_t;

  exp_t exp_q[$];

  gray_conv_arbiter #(
    .N (4),
    .R (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_mode  (req_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a transfer happens on the edge after a negedge with valid && ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL spurious output: got data 0x%0h id %0d, want none", out_data, out_id);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_id", 32'(out_id), 32'(e.id));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d, input int r);
    exp_t e;
    e.data = d;
    e.id   = 2'(r);
    exp_q.push_back(e);
  endtask

  // Returns on a negedge in IDLE with a grant showing (accept on next posedge).
  task automatic wait_grant(input int r);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 20);
    check($sformatf("grant r%0d", r), 32'(req_ready), 32'(1) << r);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 0);
    check({tag, " out_data"}, 32'(out_data), 0);
    check({tag, " out_id"}, 32'(out_id), 0);
    check({tag, " req_ready"}, 32'(req_ready), 0);
    check({tag, " busy"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    step();
    step();
    check_reset_vals("reset");
    rst = 1'b0;
  endtask

  // Full transaction with out_ready=1, checking the CONV/OUT timing.
  task automatic do_txn(input int r, input logic [3:0] d, input logic m, input logic [3:0] e);
    req_data[r*4 +: 4] = d;
    req_mode[r]        = m;
    req_valid[r]       = 1'b1;
    wait_grant(r);
    push(e, r);
    step();
    req_valid[r] = 1'b0;
    check("conv busy", 32'(busy), 1);
    check("conv out_valid", 32'(out_valid), 0);
    check("conv req_ready", 32'(req_ready), 0);
    step();
    check("out_valid latency", 32'(out_valid), 1);
    step();
    check("out_valid drop", 32'(out_valid), 0);
    check("idle busy", 32'(busy), 0);
  endtask

  int         order[5] = '{0, 1, 2, 3, 0};
  logic [3:0] rr_exp[4] = '{4'b0001, 4'b0011, 4'b0110, 4'b1100};

  initial begin
    int last;
    int n;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_mode  = '0;
    out_ready = 1'b1;
    do_reset();

    // Basic vectors and boundary words.
    do_txn(0, 4'b1011, 1'b0, 4'b1110);
    do_txn(0, 4'b1110, 1'b1, 4'b1011);
    do_txn(1, 4'b0000, 1'b0, 4'b0000);
    do_txn(2, 4'b0000, 1'b1, 4'b0000);
    do_txn(3, 4'b1111, 1'b0, 4'b1000);
    do_txn(0, 4'b1111, 1'b1, 4'b1010);

    // Round robin with all requesters valid: 0,1,2,3,0, one accept per 3 cycles.
    do_reset();
    req_data  = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    req_mode  = '0;
    req_valid = 4'hF;
    last      = 0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(order[i]);
      push(rr_exp[order[i]], order[i]);
      if (i > 0) check("accept spacing", 32'(cyc - last), 3);
      last = cyc;
    end
    step();
    req_valid = '0;
    repeat (4) step();

    // Backpressure: ptr=1, result held while req2 waits.
    req_data[7:4] = 4'b0110;
    req_mode[1]   = 1'b0;
    req_valid[1]  = 1'b1;
    out_ready     = 1'b0;
    wait_grant(1);
    push(4'b0101, 1);
    step();
    req_valid[1]   = 1'b0;
    req_data[11:8] = 4'b0011;
    req_mode[2]    = 1'b1;
    req_valid[2]   = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp out_valid", 32'(out_valid), 1);
      check("bp out_data", 32'(out_data), 'h5);
      check("bp out_id", 32'(out_id), 1);
      check("bp req_ready", 32'(req_ready), 0);
    end
    step();
    out_ready = 1'b1;
    step();
    check("bp grant r2", 32'(req_ready), 'h4);
    push(4'b0010, 2);
    step();
    req_valid[2] = 1'b0;
    repeat (3) step();

    // Fairness: bring ptr to 2, then r1 and r3 contend -> r3 first.
    do_txn(1, 4'b1100, 1'b1, 4'b1000);
    req_data[7:4]   = 4'b1001;
    req_mode[1]     = 1'b0;
    req_data[15:12] = 4'b0111;
    req_mode[3]     = 1'b1;
    req_valid       = 4'b1010;
    wait_grant(3);
    push(4'b0101, 3);
    step();
    req_valid[3] = 1'b0;
    wait_grant(1);
    push(4'b1101, 1);
    step();
    req_valid[1] = 1'b0;
    repeat (3) step();

    // Reset during CONV: word discarded, ptr back to 0.
    req_data[3:0] = 4'b1010;
    req_mode[0]   = 1'b0;
    req_valid[0]  = 1'b1;
    wait_grant(0);
    step();
    req_valid = '0;
    rst       = 1'b1;
    step();
    check_reset_vals("conv-reset");
    rst = 1'b0;
    // ptr=0 picks r0 over r2; a stale ptr=1 would pick r2.
    req_data[11:8] = 4'b1000;
    req_mode[2]    = 1'b1;
    req_valid[2]   = 1'b1;
    do_txn(0, 4'b0101, 1'b0, 4'b0111);
    do_txn(2, 4'b1000, 1'b1, 4'b1111);

    // Reset during OUT: presented-but-unaccepted word is discarded.
    out_ready       = 1'b0;
    req_data[15:12] = 4'b0110;
    req_mode[3]     = 1'b0;
    req_valid[3]    = 1'b1;
    wait_grant(3);
    step();
    req_valid = '0;
    step();
    check("out-reset pre out_valid", 32'(out_valid), 1);
    check("out-reset pre out_data", 32'(out_data), 'h5);
    rst = 1'b1;
    step();
    check_reset_vals("out-reset");
    rst       = 1'b0;
    out_ready = 1'b1;
    // ptr=0 picks r1 before r3.
    req_data[15:12] = 4'b0100;
    req_mode[3]     = 1'b1;
    req_valid[3]    = 1'b1;
    do_txn(1, 4'b0011, 1'b0, 4'b0010);
    do_txn(3, 4'b0100, 1'b1, 4'b0111);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check("scoreboard drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_miss);
    $fatal(1, "watchdog expired");
  end

endmodule
